ldpc_cyclic_bf_decoder: RTL and testbench



---
 rtl/ldpc_cyclic_bf_decoder.sv | 173 +++++++++++++++++
 tb/tb_ldpc_cyclic_bf_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_cyclic_bf_decoder.sv
// ---------------------------------------------------------------------------
// ldpc_cyclic_bf_decoder
//
// Iterative bit-flipping decoder for cyclic (circulant-H) LDPC and
// difference-set codes. One codeword is in flight at a time: a word is
// accepted in IDLE and decoded in ITER, at one flip iteration per clock. It is
// then presented in DONE until the sink takes it.
//
// Parameters
//   N         code length in bits
//   H_ROW     first row of the N x N circulant parity-check matrix;
//             check j covers bits (j+k) mod N for every set bit k
//   FLIP_THR  a bit flips when its unsatisfied-check count is >= FLIP_THR
//   MAX_ITER  maximum number of flip iterations (0 = syndrome check only)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_data    hard-decision received word (bit i = code position i)
//   in_valid   in_data is valid
//   in_ready   decoder can accept a word (IDLE only)
//   out_data   decoded word
//   out_ok     final syndrome is zero
//   out_iters  number of flip iterations applied
//   out_valid  outputs are valid
//   out_ready  sink accepts the outputs
//   stat_frames / stat_fails  (only with LDPC_BF_STATS_EN defined)
//              saturating 16-bit counts of delivered words and of delivered
//              words whose syndrome was non-zero
//
// Optional feature macro: LDPC_BF_STATS_EN
// ---------------------------------------------------------------------------
module ldpc_cyclic_bf_decoder #(
  parameter int N = 7,
  parameter logic [N-1:0] H_ROW = 7'b0001011,
  parameter int FLIP_THR = 2,
  parameter int MAX_ITER = 2,
  localparam int IW = (MAX_ITER + 1 > 2) ? $clog2(MAX_ITER + 1) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  out_data,
  output logic          out_ok,
  output logic [IW-1:0] out_iters,
  output logic          out_valid,
  input  logic          out_ready
`ifdef LDPC_BF_STATS_EN
  ,
  output logic [15:0]   stat_frames,
  output logic [15:0]   stat_fails
`endif
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    cw, cw_nxt;
  logic [IW-1:0]   iter, iter_nxt;
  logic            ok_r, ok_nxt;
  logic            vld_r, vld_nxt;

  logic [N-1:0]    syn;
  logic [N-1:0]    flip;
  int              cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Syndrome of the current codeword: one parity check per circulant row.
  always_comb begin
    syn = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (H_ROW[k]) syn[j] = syn[j] ^ cw[(j + k) % N];
      end
    end
  end

  // Bit i sits in check j = (i - k) mod N for each tap k; count the failing ones.
  always_comb begin
    flip = '0;
    cnt  = 0;
    for (int i = 0; i < N; i++) begin
      cnt = 0;
      for (int k = 0; k < N; k++) begin
        if (H_ROW[k] && syn[(i + N - k) % N]) cnt = cnt + 1;
      end
      flip[i] = (cnt >= FLIP_THR);
    end
  end

  always_comb begin
    state_nxt = state;
    cw_nxt    = cw;
    iter_nxt  = iter;
    ok_nxt    = ok_r;
    vld_nxt   = vld_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cw_nxt    = in_data;
          iter_nxt  = '0;
          ok_nxt    = 1'b0;
          state_nxt = ITER;
        end
      end
      ITER: begin
        if (syn == '0) begin
          ok_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (int'(iter) == MAX_ITER || flip == '0) begin
          // Iteration budget spent, or no bit reaches the threshold (stall).
          ok_nxt    = 1'b0;
          state_nxt = DONE;
        end else begin
          cw_nxt   = cw ^ flip;
          iter_nxt = iter + 1'b1;
        end
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE, giving 2+k latency.
        if (!vld_r) begin
          vld_nxt = 1'b1;
        end else if (out_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cw    <= '0;
      iter  <= '0;
      ok_r  <= 1'b0;
      vld_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cw    <= cw_nxt;
      iter  <= iter_nxt;
      ok_r  <= ok_nxt;
      vld_r <= vld_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_data  = cw;
  assign out_iters = iter;
  assign out_ok    = ok_r;
  assign out_valid = vld_r;

`ifdef LDPC_BF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_fails  <= '0;
    end else if (vld_r && out_ready) begin
      stat_frames <= sat_inc(stat_frames);
      if (!ok_r) stat_fails <= sat_inc(stat_fails);
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_ldpc_cyclic_bf_decoder.sv
// Bench for ldpc_cyclic_bf_decoder: a default instance (MAX_ITER=2) and a
// syndrome-check-only instance (MAX_ITER=0), each with its own scoreboard.
module tb_ldpc_cyclic_bf_decoder;

  typedef struct {
    logic [6:0] d;
    logic       ok;
    int         it;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // default instance
  logic       rst, in_valid, in_ready, out_ok, out_valid, out_ready;
  logic [6:0] in_data, out_data;
  logic [1:0] out_iters;
  // MAX_ITER = 0 instance
  logic       rst0, in_valid0, in_ready0, out_ok0, out_valid0, out_ready0;
  logic [6:0] in_data0, out_data0;
  logic [0:0] out_iters0;
`ifdef LDPC_BF_STATS_EN
  logic [15:0] stat_frames, stat_fails, stat_frames0, stat_fails0;
`endif

  exp_t q[$], q0[$];
  int   acc_q[$], acc_q0[$];
  exp_t e, e0;
  int   lat_m, lat_m0;
  bit   seen_m = 0, seen_m0 = 0, post_hs = 0, post_hs0 = 0;

  ldpc_cyclic_bf_decoder #(.N(7), .H_ROW(7'b0001011), .FLIP_THR(2), .MAX_ITER(2)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ok(out_ok), .out_iters(out_iters), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef LDPC_BF_STATS_EN
    , .stat_frames(stat_frames), .stat_fails(stat_fails)
`endif
  );

  ldpc_cyclic_bf_decoder #(.N(7), .H_ROW(7'b0001011), .FLIP_THR(2), .MAX_ITER(0)) u_dut0 (
    .clk(clk), .rst(rst0), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .out_data(out_data0), .out_ok(out_ok0), .out_iters(out_iters0), .out_valid(out_valid0),
    .out_ready(out_ready0)
`ifdef LDPC_BF_STATS_EN
    , .stat_frames(stat_frames0), .stat_fails(stat_fails0)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Monitor, default instance
  always @(negedge clk) begin
    if (!rst) begin
      if (post_hs) begin
        chk("in_ready_after_hs", int'(in_ready), 1);
        chk("valid_drop_after_hs", int'(out_valid), 0);
        post_hs = 0;
      end
      if (out_valid && !seen_m) begin
        seen_m = 1;
        if (acc_q.size() == 0) fail("output_without_accept");
        else lat_m = cyc - acc_q.pop_front();
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail("unexpected_output");
        else begin
          e = q.pop_front();
          chk("out_data", int'(out_data), int'(e.d));
          chk("out_ok", int'(out_ok), int'(e.ok));
          chk("out_iters", int'(out_iters), e.it);
          chk("latency", lat_m, e.lat);
        end
        seen_m  = 0;
        post_hs = 1;
      end
    end
  end

  // Monitor, MAX_ITER = 0 instance
  always @(negedge clk) begin
    if (!rst0) begin
      if (post_hs0) begin
        chk("in_ready0_after_hs", int'(in_ready0), 1);
        post_hs0 = 0;
      end
      if (out_valid0 && !seen_m0) begin
        seen_m0 = 1;
        if (acc_q0.size() == 0) fail("output0_without_accept");
        else lat_m0 = cyc - acc_q0.pop_front();
      end
      if (out_valid0 && out_ready0) begin
        if (q0.size() == 0) fail("unexpected_output0");
        else begin
          e0 = q0.pop_front();
          chk("out_data0", int'(out_data0), int'(e0.d));
          chk("out_ok0", int'(out_ok0), int'(e0.ok));
          chk("out_iters0", int'(out_iters0), e0.it);
          chk("latency0", lat_m0, e0.lat);
        end
        seen_m0  = 0;
        post_hs0 = 1;
      end
    end
  end

  // Offer a word to instance sel (0 = default, 1 = MAX_ITER=0) and queue its
  // expected result. With junk set, in_valid stays high with garbage data for
  // two cycles after the accept, which the decoder must ignore.
  task automatic send(input bit sel, input logic [6:0] d, input logic [6:0] ed,
                      input logic eok, input int eit, input int elat, input bit junk);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    while (!(sel ? in_ready0 : in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(sel ? in_ready0 : in_ready)) begin
      fail("send_timeout");
      return;
    end
    x.d = ed; x.ok = eok; x.it = eit; x.lat = elat;
    if (sel) begin in_valid0 = 1'b1; in_data0 = d; q0.push_back(x); end
    else     begin in_valid  = 1'b1; in_data  = d; q.push_back(x);  end
    @(posedge clk);
    #1;
    if (sel) acc_q0.push_back(cyc);
    else     acc_q.push_back(cyc);
    if (junk) begin
      if (sel) in_data0 = 7'h7F;
      else     in_data  = 7'h7F;
      repeat (2) @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_valid0 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q0.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || q0.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; rst0 = 1'b1;
    in_valid = 1'b0; in_valid0 = 1'b0;
    in_data = 7'h00; in_data0 = 7'h00;
    out_ready = 1'b1; out_ready0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out_ok", int'(out_ok), 0);
    chk("reset_out_iters", int'(out_iters), 0);
    chk("reset_in_ready0", int'(in_ready0), 1);
    rst = 1'b0; rst0 = 1'b0;

    // clean word, single errors at bits 0/3/6, a double error that the code
    // pulls back to 7'h74 in one pass, and the all-zero codeword
    send(0, 7'h74, 7'h74, 1'b1, 0, 2, 0);
    send(0, 7'h75, 7'h74, 1'b1, 1, 3, 1);
    send(0, 7'h7C, 7'h74, 1'b1, 1, 3, 0);
    send(0, 7'h34, 7'h74, 1'b1, 1, 3, 0);
    send(0, 7'h03, 7'h74, 1'b1, 1, 3, 0);
    send(0, 7'h00, 7'h00, 1'b1, 0, 2, 0);
    wait_drain();

    // backpressure: hold the sink off for 5 cycles once out_valid is up
    out_ready = 1'b0;
    send(0, 7'h74, 7'h74, 1'b1, 0, 2, 0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", int'(out_valid), 1);
      chk("bp_data_held", int'(out_data), 'h74);
      chk("bp_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    send(0, 7'h00, 7'h00, 1'b1, 0, 2, 0);
    wait_drain();

    // reset while a word is in ITER: it must vanish without an output
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 7'h75;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rst_test_in_iter", int'(in_ready), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_valid", int'(out_valid), 0);
    end
    chk("rst_in_ready", int'(in_ready), 1);
`ifdef LDPC_BF_STATS_EN
    chk("rst_stat_frames", int'(stat_frames), 0);
    chk("rst_stat_fails", int'(stat_fails), 0);
`endif

    // syndrome-check-only instance
    send(1, 7'h74, 7'h74, 1'b1, 0, 2, 0);
    send(1, 7'h75, 7'h75, 1'b0, 0, 2, 0);
    send(1, 7'h74, 7'h74, 1'b1, 0, 2, 0);
    wait_drain();
`ifdef LDPC_BF_STATS_EN
    chk("stat_frames0", int'(stat_frames0), 3);
    chk("stat_fails0", int'(stat_fails0), 1);
`endif

    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size() + q0.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
